core_inst_sequencer: RTL and testbench

- Generates the 49-bit `inst` word that drives `core` for one weight-stationary tile, so the testbench no longer hand-builds instructions.
- Tile sequence: fetch ROW weight vectors from pmem into L0, shift them into the array, fetch N activation vectors from xmem into L0, execute, then drain OFIFO into omem.
- Sits between the top-level control/testbench and `core`; it only sequences the existing datapath and adds no datapath of its own.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/core_inst_sequencer_sram_rd_issue.sv | 62 ++++++
 rtl/core_inst_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : inst word bit positions, NOP word and sequencer state encoding
// Rev 1.0
// ============================================================================
package core_pkg;

    localparam int INST_W      = 49;
    localparam int INST_AW     = 11;

    localparam int CEN_OMEM_B  = 48;
    localparam int WEN_OMEM_B  = 47;
    localparam int A_OMEM_LSB  = 36;
    localparam int MODE_B      = 35;
    localparam int DATA_MODE_B = 34;
    localparam int ACC_B       = 33;
    localparam int CEN_PMEM_B  = 32;
    localparam int WEN_PMEM_B  = 31;
    localparam int A_PMEM_LSB  = 20;
    localparam int CEN_XMEM_B  = 19;
    localparam int WEN_XMEM_B  = 18;
    localparam int A_XMEM_LSB  = 7;
    localparam int OFIFO_RD_B  = 6;
    localparam int IFIFO_WR_B  = 5;
    localparam int IFIFO_RD_B  = 4;
    localparam int L0_RD_B     = 3;
    localparam int L0_WR_B     = 2;
    localparam int EXECUTE_B   = 1;
    localparam int LOAD_B      = 0;

    // All SRAMs deselected with write-enable inactive; every other bit low.
    localparam logic [INST_W-1:0] NOP_INST =
        (49'd1 << CEN_OMEM_B) | (49'd1 << WEN_OMEM_B) |
        (49'd1 << CEN_PMEM_B) | (49'd1 << WEN_PMEM_B) |
        (49'd1 << CEN_XMEM_B) | (49'd1 << WEN_XMEM_B);

    localparam logic [INST_W-1:0] MODE_ONLY_INST = NOP_INST | (49'd1 << MODE_B);

    // Sequencer does not drive the accumulate or input-FIFO controls.
    localparam logic [INST_W-1:0] TIED_LOW_MASK =
        (49'd1 << ACC_B) | (49'd1 << IFIFO_WR_B) | (49'd1 << IFIFO_RD_B);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WT_FETCH  = 3'd1,
        S_WT_LOAD   = 3'd2,
        S_WT_SETTLE = 3'd3,
        S_ACT_FETCH = 3'd4,
        S_EXEC      = 3'd5,
        S_DRAIN     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/core_inst_sequencer_sram_rd_issue.sv
`default_nettype none
// ============================================================================
// sram_rd_issue : issues len consecutive SRAM reads from base; l0_wr follows
//                 each read by one cycle. Outputs are next-cycle values.
// Rev 1.0
// ============================================================================
module sram_rd_issue #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W:0]    len,
    output logic              rd_nxt,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              l0_wr_nxt,
    output logic              active,
    output logic              last
);

    logic              r_active;
    logic [CNT_W:0]    r_idx;
    logic [CNT_W:0]    r_len;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W:0]    w_idx_nxt;

    always_comb begin
        w_idx_nxt = '0;
        rd_nxt    = 1'b0;
        if (start) begin
            rd_nxt = (len != '0);
        end else if (r_active) begin
            w_idx_nxt = r_idx + 1'b1;
            rd_nxt    = (w_idx_nxt < r_len);
        end
    end

    assign addr_nxt  = (start ? base : r_base) + ADDR_W'(w_idx_nxt);
    assign l0_wr_nxt = r_active;
    assign active    = r_active;
    assign last      = r_active && ((r_idx + 1'b1) == r_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_len    <= '0;
            r_base   <= '0;
        end else begin
            r_active <= rd_nxt;
            r_idx    <= w_idx_nxt;
            if (start) begin
                r_len  <= len;
                r_base <= base;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_inst_sequencer.sv
`default_nettype none
// ============================================================================
// core_inst_sequencer : builds the core inst word for one weight-stationary
//                       tile (weight fetch/load, activation fetch, execute, drain)
// Rev 1.0
// ============================================================================
module core_inst_sequencer
    import core_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11,
    parameter int SETTLE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_act,
    input  logic [ADDR_W-1:0] wt_base,
    input  logic [ADDR_W-1:0] act_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W:0] C_ROW_LEN     = (CNT_W+1)'(ROW);
    localparam logic [CNT_W:0] C_COL_LAST    = (CNT_W+1)'(COL - 1);
    localparam logic [CNT_W:0] C_SETTLE_LAST = (CNT_W+1)'(SETTLE - 1);

    state_t              r_state;
    logic [INST_W-1:0]   r_inst;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_num_act;
    logic [ADDR_W-1:0]   r_act_base;
    logic [ADDR_W-1:0]   r_out_base;
    logic [CNT_W:0]      r_cnt;
    logic [CNT_W:0]      r_rd_cnt;
    logic [CNT_W:0]      r_wr_cnt;

    logic [CNT_W:0]      w_num_act;
    logic                w_settle_end;
    logic                w_fs_start;
    logic [ADDR_W-1:0]   w_fs_base;
    logic [CNT_W:0]      w_fs_len;
    logic                w_rd_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_l0_wr_nxt;
    logic                w_fs_active;
    logic                w_fs_last;

    assign w_num_act    = {1'b0, r_num_act};
    assign w_settle_end = (r_state == S_WT_SETTLE) && (r_cnt == C_SETTLE_LAST);
    assign w_fs_start   = ((r_state == S_IDLE) && start) ||
                          (w_settle_end && (r_num_act != '0));
    assign w_fs_base    = (r_state == S_IDLE) ? wt_base : r_act_base;
    assign w_fs_len     = (r_state == S_IDLE) ? C_ROW_LEN : w_num_act;

    sram_rd_issue #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_rd_issue (
        .clk       (clk),
        .reset     (reset),
        .start     (w_fs_start),
        .base      (w_fs_base),
        .len       (w_fs_len),
        .rd_nxt    (w_rd_nxt),
        .addr_nxt  (w_addr_nxt),
        .l0_wr_nxt (w_l0_wr_nxt),
        .active    (w_fs_active),
        .last      (w_fs_last)
    );

    // r_inst is loaded with the word for the state being entered, so inst and
    // r_state always describe the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_inst     <= NOP_INST;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_num_act  <= '0;
            r_act_base <= '0;
            r_out_base <= '0;
            r_cnt      <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_inst <= MODE_ONLY_INST;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_inst <= NOP_INST;
                    if (start) begin
                        r_state                           <= S_WT_FETCH;
                        r_busy                            <= 1'b1;
                        r_num_act                         <= num_act;
                        r_act_base                        <= act_base;
                        r_out_base                        <= out_base;
                        r_inst[MODE_B]                    <= 1'b1;
                        r_inst[DATA_MODE_B]               <= 1'b1;
                        r_inst[CEN_PMEM_B]                <= ~w_rd_nxt;
                        r_inst[A_PMEM_LSB +: INST_AW]     <= w_addr_nxt;
                    end
                end
                S_WT_FETCH: begin
                    r_inst[L0_WR_B] <= w_l0_wr_nxt;
                    if (w_fs_last) begin
                        r_state           <= S_WT_LOAD;
                        r_cnt             <= '0;
                        r_inst[L0_RD_B]   <= 1'b1;
                        r_inst[LOAD_B]    <= 1'b1;
                    end else begin
                        r_inst[DATA_MODE_B]           <= 1'b1;
                        r_inst[CEN_PMEM_B]            <= ~w_rd_nxt;
                        r_inst[A_PMEM_LSB +: INST_AW] <= w_addr_nxt;
                    end
                end
                S_WT_LOAD: begin
                    if (r_cnt == C_COL_LAST) begin
                        r_state <= S_WT_SETTLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt           <= r_cnt + 1'b1;
                        r_inst[L0_RD_B] <= 1'b1;
                        r_inst[LOAD_B]  <= 1'b1;
                    end
                end
                S_WT_SETTLE: begin
                    if (w_settle_end) begin
                        if (r_num_act == '0) begin
                            r_state <= S_DONE;
                            r_inst  <= NOP_INST;
                            r_done  <= 1'b1;
                        end else begin
                            r_state                       <= S_ACT_FETCH;
                            r_inst[CEN_XMEM_B]            <= ~w_rd_nxt;
                            r_inst[A_XMEM_LSB +: INST_AW] <= w_addr_nxt;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACT_FETCH: begin
                    // One extra cycle after the last read carries only its l0_wr.
                    if (w_fs_active) begin
                        r_inst[L0_WR_B] <= w_l0_wr_nxt;
                        if (w_rd_nxt) begin
                            r_inst[CEN_XMEM_B]            <= 1'b0;
                            r_inst[A_XMEM_LSB +: INST_AW] <= w_addr_nxt;
                        end
                    end else begin
                        r_state            <= S_EXEC;
                        r_cnt              <= '0;
                        r_inst[L0_RD_B]    <= 1'b1;
                        r_inst[EXECUTE_B]  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if ((r_cnt + 1'b1) == w_num_act) begin
                        r_state  <= S_DRAIN;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                    end else begin
                        r_cnt             <= r_cnt + 1'b1;
                        r_inst[L0_RD_B]   <= 1'b1;
                        r_inst[EXECUTE_B] <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!r_inst[CEN_OMEM_B] && (r_wr_cnt == w_num_act)) begin
                        r_state <= S_DONE;
                        r_inst  <= NOP_INST;
                        r_done  <= 1'b1;
                    end else begin
                        if (ofifo_valid && (r_rd_cnt < w_num_act)) begin
                            r_inst[OFIFO_RD_B] <= 1'b1;
                            r_rd_cnt           <= r_rd_cnt + 1'b1;
                        end
                        if (r_inst[OFIFO_RD_B]) begin
                            r_inst[CEN_OMEM_B]            <= 1'b0;
                            r_inst[WEN_OMEM_B]            <= 1'b0;
                            r_inst[A_OMEM_LSB +: INST_AW] <= r_out_base + ADDR_W'(r_wr_cnt);
                            r_wr_cnt                      <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_inst  <= NOP_INST;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_inst  <= NOP_INST;
                end
            endcase
        end
    end

    assign inst = r_inst & ~TIED_LOW_MASK;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_inst_sequencer.sv
`default_nettype none
// ============================================================================
// tb_core_inst_sequencer : directed tiles checked cycle by cycle against
//                          hand-derived instruction timelines
// Rev 1.0
// ============================================================================
module tb_core_inst_sequencer;
    import core_pkg::*;

    localparam int NC = 50;
    localparam logic [48:0] C_NOP = 49'h1_8001_800C_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] num_act;
    logic [10:0] wt_base;
    logic [10:0] act_base;
    logic [10:0] out_base;
    logic        ofifo_valid;
    logic [48:0] inst;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [48:0] rec_inst [NC];
    logic        rec_busy [NC];
    logic        rec_done [NC];
    logic [48:0] exp_inst [NC];
    logic        exp_busy [NC];
    logic        exp_done [NC];

    core_inst_sequencer #(
        .ROW(8), .COL(8), .ADDR_W(11), .CNT_W(11), .SETTLE(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_act     (num_act),
        .wt_base     (wt_base),
        .act_base    (act_base),
        .out_base    (out_base),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic valid_at(input int vmode, input int c);
        int pat [7];
        int idx;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        idx = c - 33;
        if (vmode == 0) return 1'b1;
        if (idx < 0)    return 1'b0;
        if (idx < 7)    return pat[idx][0];
        return 1'b1;
    endfunction

    task automatic launch(input logic [10:0] wt, input logic [10:0] act,
                          input logic [10:0] out, input logic [10:0] n);
        @(negedge clk);
        wt_base = wt; act_base = act; out_base = out; num_act = n;
        ofifo_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle 0 is the first cycle after the edge that accepted start.
    task automatic record(input int vmode, input bit poke);
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            rec_inst[c] = inst;
            rec_busy[c] = busy;
            rec_done[c] = done;
            ofifo_valid = valid_at(vmode, c);
            if (poke && c == 5) begin
                start = 1'b1; wt_base = 11'h3A0; num_act = 11'd0;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic build_exp(input logic [10:0] wt, input logic [10:0] act,
                             input logic [10:0] out, input int n,
                             input int r0, input int r1, input int r2, input int r3);
        int ro [4];
        int d;
        int done_c;
        logic [48:0] e;
        ro = '{r0, r1, r2, r3};
        d = 25 + 2 * n;
        done_c = (n == 0) ? 24 : d + ro[n-1] + 2;
        for (int c = 0; c < NC; c++) begin
            e = C_NOP;
            if (c < done_c) e[MODE_B] = 1'b1;
            if (c < 8) begin
                e[CEN_PMEM_B] = 1'b0;
                e[A_PMEM_LSB +: 11] = 11'(wt + c);
                e[DATA_MODE_B] = 1'b1;
            end
            if (c >= 1 && c < 9) e[L0_WR_B] = 1'b1;
            if (c >= 8 && c < 16) begin
                e[L0_RD_B] = 1'b1;
                e[LOAD_B]  = 1'b1;
            end
            if (n > 0) begin
                if (c >= 24 && c < 24 + n) begin
                    e[CEN_XMEM_B] = 1'b0;
                    e[A_XMEM_LSB +: 11] = 11'(act + (c - 24));
                end
                if (c >= 25 && c < 25 + n) e[L0_WR_B] = 1'b1;
                if (c >= 25 + n && c < d) begin
                    e[L0_RD_B]   = 1'b1;
                    e[EXECUTE_B] = 1'b1;
                end
                for (int k = 0; k < n; k++) begin
                    if (c == d + ro[k]) e[OFIFO_RD_B] = 1'b1;
                    if (c == d + ro[k] + 1) begin
                        e[CEN_OMEM_B] = 1'b0;
                        e[WEN_OMEM_B] = 1'b0;
                        e[A_OMEM_LSB +: 11] = 11'(out + k);
                    end
                end
            end
            exp_inst[c] = e;
            exp_busy[c] = (c <= done_c);
            exp_done[c] = (c == done_c);
        end
    endtask

    task automatic verify_tile(input string name);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s inst c%0d", name, c), 64'(rec_inst[c]), 64'(exp_inst[c]));
            check($sformatf("%s busy c%0d", name, c), 64'(rec_busy[c]), 64'(exp_busy[c]));
            check($sformatf("%s done c%0d", name, c), 64'(rec_done[c]), 64'(exp_done[c]));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_act = '0;
        wt_base = '0; act_base = '0; out_base = '0; ofifo_valid = 1'b0;
        #1 reset = 1'b0;

        // Reset held for three cycles, then idle with no start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst inst %0d", i), 64'(inst), 64'(C_NOP));
            check($sformatf("rst busy %0d", i), 64'(busy), 64'd0);
            check($sformatf("rst done %0d", i), 64'(done), 64'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle inst %0d", i), 64'(inst), 64'(C_NOP));
            check($sformatf("idle busy %0d", i), 64'(busy), 64'd0);
            check($sformatf("idle done %0d", i), 64'(done), 64'd0);
        end

        // Weights only: no activations, no execute, no omem writes.
        launch(11'h010, 11'h000, 11'h000, 11'd0);
        record(0, 1'b0);
        build_exp(11'h010, 11'h000, 11'h000, 0, 0, 0, 0, 0);
        verify_tile("noact");

        // Full tile, output FIFO always valid; a start mid-tile must be ignored.
        launch(11'h020, 11'h100, 11'h200, 11'd4);
        record(0, 1'b1);
        build_exp(11'h020, 11'h100, 11'h200, 4, 1, 2, 3, 4);
        verify_tile("full");

        // Output FIFO valid toggles 1,0,0,1,1,0,1 from the first drain cycle.
        launch(11'h020, 11'h100, 11'h200, 11'd4);
        record(1, 1'b0);
        build_exp(11'h020, 11'h100, 11'h200, 4, 1, 4, 5, 7);
        verify_tile("toggle");

        // Every address field wraps past 0x7FF.
        launch(11'h7FC, 11'h7FD, 11'h7FE, 11'd4);
        record(0, 1'b0);
        build_exp(11'h7FC, 11'h7FD, 11'h7FE, 4, 1, 2, 3, 4);
        verify_tile("wrap");

        // Reset asserted in the middle of EXEC.
        launch(11'h030, 11'h140, 11'h240, 11'd4);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            ofifo_valid = 1'b1;
        end
        check("pre-reset execute", 64'(inst[EXECUTE_B]), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst inst", 64'(inst), 64'(C_NOP));
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        @(negedge clk);
        check("midrst hold inst", 64'(inst), 64'(C_NOP));
        reset = 1'b1;
        @(negedge clk);
        check("postrst idle inst", 64'(inst), 64'(C_NOP));
        check("postrst idle busy", 64'(busy), 64'd0);

        launch(11'h050, 11'h160, 11'h260, 11'd4);
        record(0, 1'b0);
        build_exp(11'h050, 11'h160, 11'h260, 4, 1, 2, 3, 4);
        verify_tile("after-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
